// File: rtl/underflow_detector_if.sv
// Bus bundle for the underflow detector: load/subtract controls, sticky-flag ack,
// and the registered accumulator and status outputs.
interface underflow_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] d;
    logic             uf_ack;
    logic [WIDTH-1:0] q;
    logic             underflow;
    logic             uf_sticky;
    logic [CNT_W-1:0] uf_count;

    modport master (
        output load, load_val, en, d, uf_ack,
        input  q, underflow, uf_sticky, uf_count
    );

    modport slave (
        input  load, load_val, en, d, uf_ack,
        output q, underflow, uf_sticky, uf_count
    );
endinterface

// File: rtl/underflow_detector.sv
// Down-counting accumulator with borrow detection, one-cycle pulse, sticky flag and
// saturating event counter. Define UNDERFLOW_SATURATE_EN to clamp q to 0 on a borrow.
module underflow_detector #(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 4,
    parameter logic [WIDTH-1:0] INIT  = 8'hFF
) (
    input logic                clk,
    input logic                rst,
    underflow_detector_if.slave bus
);
    typedef enum logic {RUN, FLAGGED} state_t;

    state_t           state_p1;
    logic [WIDTH-1:0] q_p1;
    logic             underflow_p1;
    logic             sticky_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic [WIDTH:0]   diff_p0;
    logic             borrow_p0;
    logic             ack_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] borrow_result(input logic [WIDTH:0] diff);
`ifdef UNDERFLOW_SATURATE_EN
        return {WIDTH{1'b0}} & diff[WIDTH-1:0];
`else
        return diff[WIDTH-1:0];
`endif
    endfunction

    // Stage p0: subtract and detect borrow; a load cycle suppresses both borrow and ack
    always_comb begin
        diff_p0   = {1'b0, q_p1} - {1'b0, bus.d};
        borrow_p0 = bus.en && !bus.load && diff_p0[WIDTH];
        ack_p0    = bus.uf_ack && !bus.load;
    end

    // Stage p1: registered accumulator, pulse, counter and sticky FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            q_p1         <= INIT;
            underflow_p1 <= 1'b0;
            sticky_p1    <= 1'b0;
            cnt_p1       <= '0;
            state_p1     <= RUN;
        end else begin
            underflow_p1 <= borrow_p0;
            if (bus.load)
                q_p1 <= bus.load_val;
            else if (bus.en)
                q_p1 <= borrow_p0 ? borrow_result(diff_p0) : diff_p0[WIDTH-1:0];
            if (borrow_p0)
                cnt_p1 <= sat_inc(cnt_p1);
            case (state_p1)
                RUN: begin
                    if (borrow_p0) begin
                        state_p1  <= FLAGGED;
                        sticky_p1 <= 1'b1;
                    end
                end
                FLAGGED: begin
                    // A borrow in the same cycle as the ack keeps the flag raised
                    if (!borrow_p0 && ack_p0) begin
                        state_p1  <= RUN;
                        sticky_p1 <= 1'b0;
                    end
                end
                default: begin
                    state_p1  <= RUN;
                    sticky_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q         = q_p1;
    assign bus.underflow = underflow_p1;
    assign bus.uf_sticky = sticky_p1;
    assign bus.uf_count  = cnt_p1;
endmodule

// File: tb/tb_underflow_detector.sv
// Self-checking bench for underflow_detector: directed scenarios plus randomized
// traffic, all compared against an integer-arithmetic reference model.
module tb_underflow_detector;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    underflow_detector_if #(.WIDTH(8), .CNT_W(4)) bus ();

    underflow_detector #(.WIDTH(8), .CNT_W(4), .INIT(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef UNDERFLOW_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int m_q, m_cnt;
    bit m_uf, m_st;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit ld, input int lv, input bit e,
                         input int dd, input bit ak);
        bit b;
        if (r) begin
            m_q = 255; m_uf = 0; m_st = 0; m_cnt = 0;
        end else if (ld) begin
            m_q = lv; m_uf = 0;
        end else begin
            b = e && (dd > m_q);
            m_uf = b;
            if (e) m_q = b ? (SAT ? 0 : m_q - dd + 256) : m_q - dd;
            if (b) begin
                m_st = 1;
                if (m_cnt < 15) m_cnt++;
            end else if (ak) begin
                m_st = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit ld, input int lv, input bit e,
                        input int dd, input bit ak);
        rst          = r;
        bus.load     = ld;
        bus.load_val = lv[7:0];
        bus.en       = e;
        bus.d        = dd[7:0];
        bus.uf_ack   = ak;
        @(posedge clk);
        model(r, ld, lv, e, dd, ak);
        #1;
        check("q", int'(bus.q), m_q);
        check("underflow", int'(bus.underflow), int'(m_uf));
        check("uf_sticky", int'(bus.uf_sticky), int'(m_st));
        check("uf_count", int'(bus.uf_count), m_cnt);
    endtask

    initial begin
        int dfill;
        m_q = 0; m_cnt = 0; m_uf = 0; m_st = 0;
        @(negedge clk);

        // reset then hold
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("reset_q", int'(bus.q), 255);
        check("reset_cnt", int'(bus.uf_count), 0);

        // no borrow: 10 - 3 three times
        step(0, 1, 10, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0);
        check("nb_q7", int'(bus.q), 7);
        step(0, 0, 0, 1, 3, 0);
        check("nb_q4", int'(bus.q), 4);
        step(0, 0, 0, 1, 3, 0);
        check("nb_q1", int'(bus.q), 1);
        check("nb_uf", int'(bus.underflow), 0);

        // borrow from q=1 with d=3
        step(0, 0, 0, 1, 3, 0);
        check("borrow_q", int'(bus.q), SAT ? 0 : 254);
        check("borrow_uf", int'(bus.underflow), 1);
        check("borrow_st", int'(bus.uf_sticky), 1);
        check("borrow_cnt", int'(bus.uf_count), 1);
        step(0, 0, 0, 0, 0, 0);
        check("pulse_once", int'(bus.underflow), 0);
        check("sticky_held", int'(bus.uf_sticky), 1);

        // equality gives zero without borrow; d==0 never borrows
        step(0, 1, 9, 0, 0, 1);
        check("load_ignores_ack", int'(bus.uf_sticky), 1);
        step(0, 0, 0, 1, 9, 0);
        check("eq_q", int'(bus.q), 0);
        check("eq_uf", int'(bus.underflow), 0);
        step(0, 0, 0, 1, 0, 0);
        check("d0_uf", int'(bus.underflow), 0);

        // ack collides with a new borrow
        step(0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 5, 1);
        check("coll_st", int'(bus.uf_sticky), 1);
        check("coll_cnt", int'(bus.uf_count), 2);
        check("coll_uf", int'(bus.underflow), 1);
        step(0, 0, 0, 0, 0, 1);
        check("ack_clears", int'(bus.uf_sticky), 0);
        step(0, 0, 0, 0, 0, 1);
        check("ack_in_run", int'(bus.uf_sticky), 0);

        // 20 consecutive borrows saturate the counter
        dfill = SAT ? 1 : 255;
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, dfill, 0);
            check("sat_uf_each", int'(bus.underflow), 1);
        end
        check("cnt_sat", int'(bus.uf_count), 15);

        // reset mid-operation discards everything
        step(1, 0, 0, 1, dfill, 0);
        check("rst_q", int'(bus.q), 255);
        check("rst_uf", int'(bus.underflow), 0);
        check("rst_st", int'(bus.uf_sticky), 0);
        check("rst_cnt", int'(bus.uf_count), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r, ld, e, ak;
            int lv, dd;
            r  = ($urandom_range(0, 79) == 0);
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            ak = ($urandom_range(0, 3) == 0);
            lv = $urandom_range(0, 255);
            dd = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            step(r, ld, lv, e, dd, ak);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
